// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, default
// latencies and FSM state encoding. Imported by the EX decoder and hazard unit too.
package mdu_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 16;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu.sv
// Multi-cycle HI/LO unit: result is computed at the start edge and held in
// pending registers until the latency counter expires. Define MDU_TRACE_EN to log HI/LO writes.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      pend_hi, pend_hi_next, pend_lo, pend_lo_next;
    logic             pend_wr, pend_wr_next;
    logic [31:0]      hi_next, lo_next;
    logic             hi_we, lo_we;

    md_op_t             op;
    logic signed [63:0] a_s, b_s, div_s;
    logic        [63:0] a_u, b_u, div_u;
    logic               b_nz;
    logic [31:0]        calc_hi, calc_lo;
    logic               calc_wr;

    // Result of the long operation, evaluated from the operands present at the start edge.
    always_comb begin
        op      = md_op_t'(md_op);
        a_s     = {{32{rs_val[31]}}, rs_val};
        b_s     = {{32{rt_val[31]}}, rt_val};
        a_u     = {32'd0, rs_val};
        b_u     = {32'd0, rt_val};
        b_nz    = (rt_val != 32'd0);
        div_s   = b_nz ? b_s : 64'sd1;
        div_u   = b_nz ? b_u : 64'd1;
        calc_hi = 32'd0;
        calc_lo = 32'd0;
        calc_wr = 1'b1;
        case (op)
            MD_MULT:  {calc_hi, calc_lo} = a_s * b_s;
            MD_MULTU: {calc_hi, calc_lo} = a_u * b_u;
            MD_DIV: begin
                calc_lo = 32'(a_s / div_s);
                calc_hi = 32'(a_s % div_s);
                calc_wr = b_nz;
            end
            MD_DIVU: begin
                calc_lo = 32'(a_u / div_u);
                calc_hi = 32'(a_u % div_u);
                calc_wr = b_nz;
            end
            default: calc_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pend_hi_next = pend_hi;
        pend_lo_next = pend_lo;
        pend_wr_next = pend_wr;
        hi_next      = hi;
        lo_next      = lo;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            state_next   = S_RUN;
                            cnt_next     = (op == MD_MULT || op == MD_MULTU) ?
                                           CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            pend_hi_next = calc_hi;
                            pend_lo_next = calc_lo;
                            pend_wr_next = calc_wr;
                        end
                        MD_MTHI: begin
                            hi_next = rs_val;
                            hi_we   = 1'b1;
                        end
                        MD_MTLO: begin
                            lo_next = rs_val;
                            lo_we   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // New starts are ignored here; the hazard unit stalls on start|busy.
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = S_IDLE;
                    if (pend_wr) begin
                        hi_next = pend_hi;
                        lo_next = pend_lo;
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pend_hi <= pend_hi_next;
            pend_lo <= pend_lo_next;
            pend_wr <= pend_wr_next;
            hi      <= hi_next;
            lo      <= lo_next;
        end
    end

`ifdef MDU_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && hi_we) $display("%0t mdu HI <= %08h", $time, hi_next);
        if (!reset && lo_we) $display("%0t mdu LO <= %08h", $time, lo_next);
    end
`else
    logic unused_we;
    assign unused_we = hi_we ^ lo_we;
`endif

    assign busy = (state == S_RUN);

endmodule
